// File: rtl/idma_rd_desc_gen.sv
// idma_rd_desc_gen: expands a 2D read command into per-row {address, word count} entries in a FWFT FIFO.
// Optional config error checking is enabled by defining IDMA_DESC_ERR_CHK_EN.
module idma_rd_desc_gen #(
    parameter int DEPTH      = 4,
    parameter int WORD_BYTES = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cfg_start,
    input  logic [31:0] cfg_base_addr,
    input  logic [31:0] cfg_row_words,
    input  logic [31:0] cfg_row_stride,
    input  logic [15:0] cfg_row_num,
    output logic        cfg_busy,
    output logic        desc_done,
    output logic        desc_err,
    output logic [31:0] raddr_fifo_raddr_in,
    output logic [31:0] raddr_fifo_rd_num_word,
    output logic        raddr_fifo_empty,
    input  logic        raddr_fifo_pop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WORD_BYTES < 1 || (WORD_BYTES & (WORD_BYTES - 1)) != 0) begin : g_bad_param
        $error("idma_rd_desc_gen: DEPTH and WORD_BYTES must be powers of two, DEPTH >= 2");
    end

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_cur_addr, r_row_words, r_row_stride;
    logic [15:0]   r_row_num, r_row_cnt;
    logic [31:0]   r_mem_addr [DEPTH];
    logic [31:0]   r_mem_words[DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_done;
    logic          w_cfg_err, w_push, w_pop, w_last_row, w_drained, w_accept;

`ifdef IDMA_DESC_ERR_CHK_EN
    logic r_err;
    assign w_cfg_err = cfg_row_words == '0
                    || (cfg_base_addr  & 32'(WORD_BYTES - 1)) != '0
                    || (cfg_row_stride & 32'(WORD_BYTES - 1)) != '0;
    assign desc_err  = r_err;
`else
    assign w_cfg_err = 1'b0;
    assign desc_err  = 1'b0;
`endif

    assign w_accept   = r_state == IDLE && cfg_start;
    // Space is judged on the registered count only; a same-cycle pop never makes room.
    assign w_push     = r_state == GEN && r_count < CW'(DEPTH);
    assign w_pop      = raddr_fifo_pop && r_count != '0;
    assign w_last_row = r_row_cnt == r_row_num - 16'd1;
    // Drained once the last remaining entry is being consumed, so done follows the final pop by one cycle.
    assign w_drained  = r_count == '0 || (r_count == CW'(1) && raddr_fifo_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cfg_start) w_state_nxt = (w_cfg_err || cfg_row_num == '0) ? DRAIN : GEN;
            GEN:     if (w_push && w_last_row) w_state_nxt = DRAIN;
            DRAIN:   if (w_drained) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cur_addr   <= '0;
            r_row_words  <= '0;
            r_row_stride <= '0;
            r_row_num    <= '0;
            r_row_cnt    <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i]  <= '0;
                r_mem_words[i] <= '0;
            end
        end else begin
            r_done  <= r_state == DRAIN && w_drained;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_accept) begin
                r_cur_addr   <= cfg_base_addr;
                r_row_words  <= cfg_row_words;
                r_row_stride <= cfg_row_stride;
                r_row_num    <= cfg_row_num;
                r_row_cnt    <= '0;
            end
            if (w_push) begin
                r_mem_addr[r_wptr]  <= r_cur_addr;
                r_mem_words[r_wptr] <= r_row_words;
                r_wptr              <= r_wptr + AW'(1);
                r_cur_addr          <= r_cur_addr + r_row_stride;
                r_row_cnt           <= r_row_cnt + 16'd1;
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
        end
    end

`ifdef IDMA_DESC_ERR_CHK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)      r_err <= 1'b0;
        else if (w_accept) r_err <= w_cfg_err;
    end
`endif

    assign cfg_busy               = r_state != IDLE;
    assign desc_done              = r_done;
    assign raddr_fifo_empty       = r_count == '0;
    assign raddr_fifo_raddr_in    = r_mem_addr[r_rptr];
    assign raddr_fifo_rd_num_word = r_mem_words[r_rptr];
endmodule

// File: tb/tb_idma_rd_desc_gen.sv
// tb_idma_rd_desc_gen: randomized scenario bench for idma_rd_desc_gen against a row-list reference model.
module tb_idma_rd_desc_gen;
    localparam int DEPTH      = 4;
    localparam int WORD_BYTES = 32;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base_addr = '0, cfg_row_words = '0, cfg_row_stride = '0;
    logic [15:0] cfg_row_num = '0;
    logic        cfg_busy, desc_done, desc_err, raddr_fifo_empty;
    logic [31:0] raddr_fifo_raddr_in, raddr_fifo_rd_num_word;
    logic        raddr_fifo_pop = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    idma_rd_desc_gen #(.DEPTH(DEPTH), .WORD_BYTES(WORD_BYTES)) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .cfg_start              (cfg_start),
        .cfg_base_addr          (cfg_base_addr),
        .cfg_row_words          (cfg_row_words),
        .cfg_row_stride         (cfg_row_stride),
        .cfg_row_num            (cfg_row_num),
        .cfg_busy               (cfg_busy),
        .desc_done              (desc_done),
        .desc_err               (desc_err),
        .raddr_fifo_raddr_in    (raddr_fifo_raddr_in),
        .raddr_fifo_rd_num_word (raddr_fifo_rd_num_word),
        .raddr_fifo_empty       (raddr_fifo_empty),
        .raddr_fifo_pop         (raddr_fifo_pop)
    );

    always #5 aclk = ~aclk;

    task automatic check_idle_outputs(input string tag);
        n_vec++;
        if (cfg_busy !== 1'b0 || desc_done !== 1'b0 || desc_err !== 1'b0 || raddr_fifo_empty !== 1'b1
            || raddr_fifo_raddr_in !== '0 || raddr_fifo_rd_num_word !== '0) begin
            n_err++;
            $display("FAIL %s: busy=%b done=%b err=%b empty=%b addr=%h words=%h, required 0 0 0 1 0 0",
                     tag, cfg_busy, desc_done, desc_err, raddr_fifo_empty, raddr_fifo_raddr_in, raddr_fifo_rd_num_word);
        end
    endtask

    // mode 0: pop every cycle, 1: random pops, 2: stall then pop every third cycle
    task automatic run_cmd(input logic [31:0] base, input logic [31:0] words, input logic [31:0] stride,
                           input logic [15:0] rows, input int mode, input bit spur);
        logic [31:0] exp_q[$];
        logic        exp_err;
        logic        pop;
        int          last_pop, idx;
        bit          done_seen;
        exp_err = 1'b0;
`ifdef IDMA_DESC_ERR_CHK_EN
        exp_err = words == 0 || base % WORD_BYTES != 0 || stride % WORD_BYTES != 0;
`endif
        if (!exp_err)
            for (int r = 0; r < int'(rows); r++) exp_q.push_back(base + stride * 32'(r));
        @(posedge aclk); #1;
        cfg_start = 1'b1; cfg_base_addr = base; cfg_row_words = words;
        cfg_row_stride = stride; cfg_row_num = rows; raddr_fifo_pop = 1'b0;
        last_pop = 1; idx = 0; done_seen = 0;
        for (int c = 1; c <= 400 && !done_seen; c++) begin
            @(posedge aclk); #1;
            cfg_start = spur && c == 3;
            cfg_base_addr = $urandom; cfg_row_words = $urandom;
            cfg_row_stride = $urandom; cfg_row_num = 16'($urandom);
            n_vec++;
            if (desc_err !== exp_err) begin
                n_err++;
                $display("FAIL desc_err c=%0d: got %b expected %b", c, desc_err, exp_err);
            end
            if (desc_done) begin
                done_seen = 1;
                n_vec++;
                if (c != last_pop + 1 || exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL done_timing: done at cycle %0d with %0d rows left, expected cycle %0d with 0",
                             c, exp_q.size(), last_pop + 1);
                end
                n_vec++;
                if (cfg_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_at_done: got %b expected 0", cfg_busy);
                end
            end else begin
                n_vec++;
                if (cfg_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy c=%0d: got %b expected 1", c, cfg_busy);
                end
            end
            pop = done_seen ? 1'b0 : mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (c >= 12 && c % 3 == 0);
            raddr_fifo_pop = pop;
            if (mode == 2 && c == 10) begin
                n_vec++;
                if (raddr_fifo_empty !== 1'b0 || raddr_fifo_raddr_in !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL stall_head: empty=%b addr=%h, required empty=0 addr=%h",
                             raddr_fifo_empty, raddr_fifo_raddr_in, exp_q[0]);
                end
            end
            if (pop && !raddr_fifo_empty) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_entry: got addr %h, expected no entry", raddr_fifo_raddr_in);
                end else begin
                    if (raddr_fifo_raddr_in !== exp_q[0] || raddr_fifo_rd_num_word !== words) begin
                        n_err++;
                        $display("FAIL entry%0d: got %h/%h expected %h/%h", idx,
                                 raddr_fifo_raddr_in, raddr_fifo_rd_num_word, exp_q[0], words);
                    end
                    void'(exp_q.pop_front());
                end
                if (mode == 0) begin
                    n_vec++;
                    if (c != 2 + idx) begin
                        n_err++;
                        $display("FAIL throughput: entry %0d at cycle %0d expected %0d", idx, c, 2 + idx);
                    end
                end
                idx++;
                last_pop = c;
            end
        end
        cfg_start = 1'b0;
        raddr_fifo_pop = 1'b0;
        if (!done_seen) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no desc_done, expected one");
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge aclk);
        #1 check_idle_outputs("reset_held");
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1 check_idle_outputs("after_reset");
    endtask

    task automatic test_basic;
        run_cmd(32'h0000_1000, 32'd8, 32'h400, 16'd3, 0, 0);
        @(posedge aclk); #1 check_idle_outputs("basic_idle");
    endtask

    task automatic test_backpressure;
        run_cmd(32'h0002_0000, 32'd16, 32'h200, 16'd6, 2, 0);
    endtask

    task automatic test_wrap;
        run_cmd(32'hFFFF_FC00, 32'd4, 32'h400, 16'd2, 0, 0);
    endtask

    task automatic test_zero_and_spurious;
        run_cmd(32'h0000_3000, 32'd8, 32'h400, 16'd0, 0, 0);
        raddr_fifo_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            n_vec++;
            if (raddr_fifo_empty !== 1'b1) begin
                n_err++;
                $display("FAIL pop_empty: empty=%b expected 1", raddr_fifo_empty);
            end
        end
        raddr_fifo_pop = 1'b0;
        run_cmd(32'h0000_2000, 32'd4, 32'h40, 16'd7, 0, 1);
        run_cmd(32'h0000_8000, 32'd2, 32'h80, 16'd8, 1, 1);
    endtask

    task automatic test_reset_mid_gen;
        @(posedge aclk); #1;
        cfg_start = 1'b1; cfg_base_addr = 32'h0000_4000; cfg_row_words = 32'd8;
        cfg_row_stride = 32'h100; cfg_row_num = 16'd8;
        @(posedge aclk); #1 cfg_start = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b0;
        #2 check_idle_outputs("reset_mid_gen");
        repeat (2) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1 check_idle_outputs("post_reset_quiet");
        end
        run_cmd(32'h0000_5000, 32'd3, 32'h60, 16'd4, 0, 0);
    endtask

`ifdef IDMA_DESC_ERR_CHK_EN
    task automatic test_err_chk;
        run_cmd(32'h0000_1004, 32'd8, 32'h400, 16'd3, 0, 0);
        run_cmd(32'h0000_1000, 32'd0, 32'h400, 16'd3, 0, 0);
        run_cmd(32'h0000_1000, 32'd8, 32'h404, 16'd3, 0, 0);
        run_cmd(32'h0000_1000, 32'd8, 32'h400, 16'd3, 0, 0);
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 25; i++) begin
            logic [15:0] rows;
            rows = 16'($urandom_range(0, 9));
            run_cmd($urandom & 32'hFFFF_FFE0, 32'($urandom_range(1, 255)), $urandom & 32'h000F_FFE0,
                    rows, $urandom_range(0, 1), rows >= 6 ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_zero_and_spurious;
        test_reset_mid_gen;
`ifdef IDMA_DESC_ERR_CHK_EN
        test_err_chk;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/idma_rd_desc_gen.md
Name: idma_rd_desc_gen

Overview:
- Upstream stage of the iDMA read path.
- Expands one 2D read command (base address, words per row, row stride, row count) into a stream of per-row (address, word-count) entries.
- Entries are held in a small first-word-fall-through FIFO that the read address manager drains through its raddr_fifo_* pop interface.
- Reports busy and a one-cycle done pulse once every entry has been consumed.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- WORD_BYTES, 32, bytes per data word (AXI_DATA_WID/8); power of two.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- cfg_start  input  1  single-cycle command start pulse.
- cfg_base_addr  input  32  byte address of row 0.
- cfg_row_words  input  32  words per row; copied into every entry.
- cfg_row_stride  input  32  byte offset between consecutive row start addresses.
- cfg_row_num  input  16  number of rows.
- cfg_busy  output  1  command in progress.
- desc_done  output  1  one-cycle pulse when the command has fully drained.
- desc_err  output  1  config error flag; present only with the optional feature.
- raddr_fifo_raddr_in  output  32  head entry address.
- raddr_fifo_rd_num_word  output  32  head entry word count.
- raddr_fifo_empty  output  1  FIFO empty.
- raddr_fifo_pop  input  1  consumer pops the head entry.

Behaviour:
- Reset values: cfg_busy=0, desc_done=0, desc_err=0, raddr_fifo_empty=1, both data outputs=0. FSM returns to IDLE; FIFO pointers and count clear.
- Reset asserted mid-command discards all entries. No done pulse is issued for the discarded command.
- FSM states and transitions:
  - IDLE: on cfg_start, latch all cfg_* inputs, set row_cnt=0 and cur_addr=cfg_base_addr.
    - If cfg_row_num==0, go to DRAIN.
    - Otherwise go to GEN.
    - cfg_busy rises the cycle after cfg_start.
  - GEN: each cycle where count<DEPTH, push {cur_addr, row_words}, then cur_addr+=row_stride and row_cnt+=1. After the push with row_cnt==row_num-1, go to DRAIN.
  - DRAIN: wait until the FIFO is empty. Then pulse desc_done for one cycle, return to IDLE and drop cfg_busy in that same cycle.
- cfg_start while cfg_busy=1 is ignored.
- cfg_* inputs are sampled only on an accepted cfg_start; later changes have no effect.
- Address arithmetic is unsigned 32-bit and wraps modulo 2^32. Stride is not checked here; 4 KB splitting is done downstream.
- FIFO push/pop rules:
  - Head is registered and valid whenever raddr_fifo_empty=0. First-word-fall-through: no read latency.
  - A pushed entry is visible at the head the cycle after the push.
  - Push is qualified only by the registered count<DEPTH. A pop in the same cycle does not free space for that cycle's push.
  - Pop while empty is ignored; pointers and count do not change.
  - Simultaneous push and pop with 0<count<DEPTH leaves count unchanged; head advances and the tail is written.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Throughput: one entry per cycle while the consumer pops every cycle.
- Zero-row command: desc_done pulses 2 cycles after cfg_start, and no entry is produced.

Optional Feature:
- Macro: IDMA_DESC_ERR_CHK_EN.
- When defined, cfg_start is checked for errors: cfg_row_words==0, cfg_base_addr not WORD_BYTES aligned, or cfg_row_stride not WORD_BYTES aligned.
- On error:
  - Go directly to DRAIN with no entries pushed.
  - Set desc_err=1, held until the next accepted cfg_start.
  - desc_done still pulses.
- When undefined, no checking is done and desc_err is tied to 0.

Test Plan:
- Basic 2D expansion: base=0x1000, row_words=8, stride=0x400, rows=3, pop held at 1 → heads 0x1000/8, 0x1400/8, 0x1800/8 on consecutive cycles; desc_done 1 cycle after the last pop; cfg_busy=0 thereafter.
- Backpressure: rows=6, DEPTH=4, pop=0 → exactly 4 entries, empty=0, GEN stalls. Then pop one per 3 cycles → remaining 2 entries pushed in order; all 6 addresses correct.
- Address wrap: base=0xFFFF_FC00, stride=0x400, rows=2 → second entry address 0x0000_0000.
- Zero rows and spurious events: rows=0 → no entries; desc_done 2 cycles after start. Pop while empty → count stays 0. cfg_start during busy → ignored, entries unchanged.
- Reset mid-GEN: deassert aresetn after 2 pushes → empty=1, busy=0, outputs 0, no desc_done. A new command then runs cleanly.
- With IDMA_DESC_ERR_CHK_EN: base=0x1004 (WORD_BYTES=32) → no entries, desc_err=1, desc_done pulses. The next valid start clears desc_err.
